// File: rtl/video_clk_prog.sv
// video_clk_prog: serial DCM_CLKGEN reprogrammer (load D, load M, GO).
// Define VIDEO_CLK_PROG_LOCK_WAIT_EN to also wait for LOCKED after PROGDONE.
module video_clk_prog #(
  parameter int DONE_TIMEOUT = 1023,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mult_m1,
  input  logic [7:0] div_m1,
  input  logic       prog_done,
  input  logic       locked,
  output logic       prog_en,
  output logic       prog_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_D,
    S_GAP_D,
    S_LOAD_M,
    S_GAP_M,
    S_GO,
    S_WAIT_DONE,
`ifdef VIDEO_CLK_PROG_LOCK_WAIT_EN
    S_WAIT_LOCK,
`endif
    S_FINISH
  } state_t;

  localparam logic [15:0] LP_DONE_TO = 16'(DONE_TIMEOUT);
`ifdef VIDEO_CLK_PROG_LOCK_WAIT_EN
  localparam logic [15:0] LP_LOCK_TO = 16'(LOCK_TIMEOUT);
`else
  logic w_unused;
  assign w_unused = ^{locked, 32'(LOCK_TIMEOUT)};
`endif

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [7:0]  r_mult;
  logic [7:0]  r_div;
  logic        r_fail;
  logic        w_fail;
  logic        r_err0;
  logic [2:0]  w_idx;

  // Counter doubles as the bit index while shifting a word out
  assign w_idx = r_cnt[2:0] - 3'd2;

  always_comb begin
    w_next = r_state;
    w_fail = r_fail;
    unique case (r_state)
      S_IDLE: begin
        w_fail = 1'b0;
        if (start && (mult_m1 != 8'd0)) w_next = S_LOAD_D;
      end
      S_LOAD_D: if (r_cnt == 16'd9) w_next = S_GAP_D;
      S_GAP_D:  w_next = S_LOAD_M;
      S_LOAD_M: if (r_cnt == 16'd9) w_next = S_GAP_M;
      S_GAP_M:  w_next = S_GO;
      S_GO:     w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (prog_done) begin
`ifdef VIDEO_CLK_PROG_LOCK_WAIT_EN
          w_next = S_WAIT_LOCK;
`else
          w_next = S_FINISH;
          w_fail = 1'b0;
`endif
        end else if (r_cnt >= LP_DONE_TO) begin
          w_next = S_FINISH;
          w_fail = 1'b1;
        end
      end
`ifdef VIDEO_CLK_PROG_LOCK_WAIT_EN
      S_WAIT_LOCK: begin
        if (locked) begin
          w_next = S_FINISH;
          w_fail = 1'b0;
        end else if (r_cnt >= LP_LOCK_TO) begin
          w_next = S_FINISH;
          w_fail = 1'b1;
        end
      end
`endif
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    prog_en   = 1'b0;
    prog_data = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = r_err0;
    unique case (r_state)
      S_IDLE: busy = 1'b0;
      S_LOAD_D: begin
        prog_en = 1'b1;
        if (r_cnt[3:0] == 4'd0)      prog_data = 1'b1;
        else if (r_cnt[3:0] == 4'd1) prog_data = 1'b0;
        else                         prog_data = r_div[w_idx];
      end
      S_LOAD_M: begin
        prog_en = 1'b1;
        if (r_cnt[3:0] < 4'd2) prog_data = 1'b1;
        else                   prog_data = r_mult[w_idx];
      end
      S_GO: prog_en = 1'b1;
      S_FINISH: begin
        busy = 1'b0;
        done = ~r_fail;
        err  = r_fail;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mult  <= '0;
      r_div   <= '0;
      r_fail  <= 1'b0;
      r_err0  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fail  <= w_fail;
      r_err0  <= (r_state == S_IDLE) && start &&
                 (mult_m1 == 8'd0);
      if ((r_state == S_IDLE) && start) begin
        r_mult <= mult_m1;
        r_div  <= div_m1;
      end
      if (w_next != r_state)     r_cnt <= '0;
      else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_clk_prog.sv
// Random scoreboard bench for video_clk_prog.
// Serial bursts and status pulses are checked against a word-level model.
`timescale 1ns/1ps
module tb_video_clk_prog;
  localparam int DTO = 15;
  localparam int LTO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       prog_done = 1'b0;
  logic       locked = 1'b0;
  logic [7:0] mult_m1 = 8'd0;
  logic [7:0] div_m1 = 8'd0;
  logic       prog_en, prog_data, busy, done, err;

  video_clk_prog #(.DONE_TIMEOUT(DTO), .LOCK_TIMEOUT(LTO)) dut (
    .clkin(clk), .rst_n(rst_n), .start(start),
    .mult_m1(mult_m1), .div_m1(div_m1),
    .prog_done(prog_done), .locked(locked),
    .prog_en(prog_en), .prog_data(prog_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = prog_en burst, 1 = done pulse, 2 = err pulse
  typedef struct {
    int          kind;
    int          cyc;
    int          len;
    logic [15:0] bits;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endfunction

  function automatic void push(int k, int c, int l, logic [15:0] b);
    exp_t e;
    e.kind = k; e.cyc = c; e.len = l; e.bits = b;
    q.push_back(e);
  endfunction

  function automatic void match(int k, int c, int l, logic [15:0] b);
    exp_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: kind %0d cyc %0d len %0d bits %h, none required",
               k, c, l, b);
      return;
    end
    e = q.pop_front();
    if (e.kind != k || e.cyc != c || e.len != l || e.bits != b) begin
      n_fail++;
      $display("FAIL sb_item: got kind %0d cyc %0d len %0d bits %h, required kind %0d cyc %0d len %0d bits %h",
               k, c, l, b, e.kind, e.cyc, e.len, e.bits);
    end
  endfunction

  // Monitor: collects prog_en bursts and status pulses
  logic        in_b = 1'b0;
  int          b_st = 0;
  int          b_len = 0;
  logic [15:0] b_bits = '0;

  always @(negedge clk) begin
    if (prog_en) begin
      if (!in_b) begin
        in_b = 1'b1; b_st = cyc; b_len = 0; b_bits = '0;
      end
      if (b_len < 16) b_bits[b_len[3:0]] = prog_data;
      b_len++;
      chk("busy_in_burst", int'(busy), 1);
    end else begin
      if (in_b) begin
        in_b = 1'b0;
        match(0, b_st, b_len, b_bits);
      end
      chk("data_when_idle", int'(prog_data), 0);
    end
    if (done || err) begin
      match(done ? 1 : 2, cyc, 0, '0);
      chk("busy_at_pulse", int'(busy), 0);
      chk("done_err_excl", int'(done && err), 0);
    end
  end

  // d: relative cycle prog_done is high (-1 none); l: same for locked
  task automatic txn(input logic [7:0] m, input logic [7:0] dv,
                     input int d, input int l, input bit noise,
                     input int rst_at);
    int          s;
    int          fin;
    bit          is_err;
    logic [15:0] wd;
    logic [15:0] wm;
    @(negedge clk);
    s = cyc;
    start = 1'b1; mult_m1 = m; div_m1 = dv;
    prog_done = 1'b0; locked = 1'b0;
    wd = {6'b0, dv, 2'b01};
    wm = {6'b0, m, 2'b11};
    if (d < 0) begin
      is_err = 1'b1; fin = 25 + DTO;
    end else begin
`ifdef VIDEO_CLK_PROG_LOCK_WAIT_EN
      if (l < 0) begin is_err = 1'b1; fin = d + LTO + 2; end
      else begin is_err = 1'b0; fin = l + 1; end
`else
      is_err = 1'b0; fin = d + 1;
`endif
    end
    if (m == 8'd0) begin
      push(2, s + 1, 0, '0);
      fin = 1;
    end else if (rst_at > 0) begin
      push(0, s + 1, 10, wd);
      push(0, s + 12, rst_at - 11, wm & 16'((1 << (rst_at - 11)) - 1));
    end else begin
      push(0, s + 1, 10, wd);
      push(0, s + 12, 10, wm);
      push(0, s + 23, 1, '0);
      push(is_err ? 2 : 1, s + fin, 0, '0);
    end
    for (int k = 1; k <= fin + 1; k++) begin
      @(negedge clk);
      chk("busy", int'(busy), int'(m != 8'd0 && k < fin));
      start = noise && (k < fin) && ($urandom_range(0, 3) == 0);
      if (noise) begin
        mult_m1 = 8'($urandom);
        div_m1  = 8'($urandom);
      end
      prog_done = (k == d) || (noise && k <= 23 && $urandom_range(0, 2) == 0);
`ifdef VIDEO_CLK_PROG_LOCK_WAIT_EN
      locked = (l >= 0 && k >= l) || (noise && k <= d && $urandom_range(0, 1) == 1);
`else
      locked = 1'($urandom_range(0, 1));
`endif
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_prog_en", int'(prog_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_err", int'(done | err), 0);
        break;
      end
    end
    start = 1'b0; prog_done = 1'b0; locked = 1'b0;
    if (rst_at > 0) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int m, dv, d, l;
    repeat (2) @(negedge clk);
    chk("reset_prog_en", int'(prog_en), 0);
    chk("reset_prog_data", int'(prog_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    rst_n = 1'b1;

    txn(8'h04, 8'h01, 30, 50, 1'b0, 0);
    txn(8'h04, 8'h01, -1, -1, 1'b0, 0);
`ifdef VIDEO_CLK_PROG_LOCK_WAIT_EN
    txn(8'h04, 8'h01, 30, -1, 1'b0, 0);
`endif
    txn(8'h00, 8'h33, -1, -1, 1'b0, 0);
    txn(8'h04, 8'h01, 30, 50, 1'b0, 15);
    txn(8'h04, 8'h01, 30, 50, 1'b0, 0);
    txn(8'hFF, 8'hFF, 24, 25, 1'b1, 0);
    txn(8'h01, 8'h00, 38, 38 + LTO, 1'b1, 0);

    repeat (25) begin
      m  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      dv = int'($urandom_range(0, 255));
      d  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(24, 38));
      l  = ($urandom_range(0, 4) == 0 || d < 0) ? -1 :
           d + int'($urandom_range(1, LTO));
      txn(8'(m), 8'(dv), d, l, 1'b1, 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
